// File: rtl/tdes_pass_sequencer.sv
// Sequences one shared single-DES core through the three Triple-DES passes (E-D-E / D-E-D).
// Optional macro TDES_SINGLE_PASS_EN: equal keys collapse the operation to a single pass.
module tdes_pass_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              enable,
  input  logic              encryptionType,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] key1,
  input  logic [DATA_W-1:0] key2,
  input  logic [DATA_W-1:0] key3,
  output logic              des_start,
  output logic              des_decrypt,
  output logic [DATA_W-1:0] des_key,
  output logic [DATA_W-1:0] des_din,
  input  logic              des_done,
  input  logic [DATA_W-1:0] des_dout,
  output logic              outputEnable,
  output logic [DATA_W-1:0] outputData,
  output logic              busy,
  output logic              error
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH, S_ERROR} state_t;

  localparam logic [9:0] TLIM = 10'(TIMEOUT - 32'd1);

  state_t            state_q, state_d;
  logic [1:0]        pass_q, pass_d;
  logic [9:0]        timer_q, timer_d;
  logic              enc_q, enc_d;
  logic [DATA_W-1:0] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic              start_q, start_d;
  logic              dec_q, dec_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [1:0]        first_pass;
  logic [1:0]        pass_inc;

  // Encrypt order key1,key2,key3; decrypt order key3,key2,key1. Middle pass always key2.
  function automatic logic [DATA_W-1:0] job_key(input logic enc, input logic [1:0] p,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] c);
    return (p == 2'd1) ? b : (((p == 2'd0) == enc) ? a : c);
  endfunction

  function automatic logic job_dec(input logic enc, input logic [1:0] p);
    return enc ? (p == 2'd1) : (p != 2'd1);
  endfunction

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    timer_d    = timer_q;
    enc_d      = enc_q;
    k1_d       = k1_q;
    k2_d       = k2_q;
    k3_d       = k3_q;
    work_d     = work_q;
    start_d    = 1'b0;
    dec_d      = dec_q;
    key_d      = key_q;
    din_d      = din_q;
    oe_d       = oe_q;
    od_d       = od_q;
    busy_d     = busy_q;
    err_d      = err_q;
    pass_inc   = pass_q + 2'd1;
`ifdef TDES_SINGLE_PASS_EN
    first_pass = (key1 == key2 && key2 == key3) ? 2'd2 : 2'd0;
`else
    first_pass = 2'd0;
`endif
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        // Job registers load straight from the ports since the shadow copy lands on this same edge.
        if (enable) begin
          state_d = S_ISSUE;
          enc_d   = encryptionType;
          k1_d    = key1;
          k2_d    = key2;
          k3_d    = key3;
          work_d  = data;
          pass_d  = first_pass;
          timer_d = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          oe_d    = 1'b0;
          start_d = 1'b1;
          dec_d   = job_dec(encryptionType, first_pass);
          key_d   = job_key(encryptionType, first_pass, key1, key2, key3);
          din_d   = data;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (des_done) begin
          work_d = des_dout;
          if (pass_q != 2'd2) begin
            state_d = S_ISSUE;
            pass_d  = pass_inc;
            start_d = 1'b1;
            dec_d   = job_dec(enc_q, pass_inc);
            key_d   = job_key(enc_q, pass_inc, k1_q, k2_q, k3_q);
            din_d   = des_dout;
          end else begin
            state_d = S_FINISH;
          end
        end else if (timer_q + 10'd1 >= TLIM) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          oe_d    = 1'b0;
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        od_d    = work_q;
        oe_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      timer_q <= '0;
      enc_q   <= 1'b0;
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      work_q  <= '0;
      start_q <= 1'b0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      din_q   <= '0;
      oe_q    <= 1'b0;
      od_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      timer_q <= timer_d;
      enc_q   <= enc_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      k3_q    <= k3_d;
      work_q  <= work_d;
      start_q <= start_d;
      dec_q   <= dec_d;
      key_q   <= key_d;
      din_q   <= din_d;
      oe_q    <= oe_d;
      od_q    <= od_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign des_start    = start_q;
  assign des_decrypt  = dec_q;
  assign des_key      = key_q;
  assign des_din      = din_q;
  assign outputEnable = oe_q;
  assign outputData   = od_q;
  assign busy         = busy_q;
  assign error        = err_q;

endmodule
